fft_frame_sequencer: RTL and testbench

- Flow-controlled sequencer for the 256-point radix-4 SDF FFT pipeline (256/64/16/4-point stages). Replaces the free-running global control counter.
- Advances all stages only on accepted input samples, or on zero-fill ticks during flush. Gaps in input therefore stall the whole pipeline coherently.
- Generates per-stage enables, output framing (valid/sop/eop/index) and protocol error flags.
- Sits between the sample source and the stage chain. The data muxing for zero fill is outside this block, driven by zero_fill.

---
 rtl/fft_frame_sequencer.sv | 160 ++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer.sv
`timescale 1ns/1ps
// fft_frame_sequencer
//   Flow-controlled control sequencer for a 256-point radix-4 SDF FFT
//   pipeline (256/64/16/4-point stages). The whole pipeline moves one step
//   ("advance") only when a sample is accepted, or on every cycle while
//   flushing. Flushing injects zero samples so the last real frame drains out.
//
//   Handshake: a sample is transferred on a cycle where in_valid=1 and
//   in_ready=1. In IDLE only a sample carrying in_sop is taken; an in_valid
//   without in_sop in IDLE is dropped and flagged on err_sop. in_ready is a
//   function of the current state only (low in FLUSH), never of in_valid.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   in_valid, in_sop   sample presented / first sample of a frame
//   in_ready           sequencer accepts samples
//   flush_req          drain the pipeline after the current frame
//   zero_fill          datapath injects 0+0j this cycle
//   stage_*_en         per-stage advance enables
//   out_valid/sop/eop  output framing, out_idx = index within output frame
//   busy               sequencer not idle
//   err_sop            one-cycle pulse on an sop protocol violation
//   dbg_state          current FSM state (observation only)
module fft_frame_sequencer #(
  parameter int N        = 256,
  parameter int EN64_DLY = 193,
  parameter int EN16_DLY = 242,
  parameter int EN4_DLY  = 255,
  parameter int OE_DLY   = 258
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_sop,
  output logic                 in_ready,
  input  logic                 flush_req,
  output logic                 zero_fill,
  output logic                 stage_256_en,
  output logic                 stage_64_en,
  output logic                 stage_16_en,
  output logic                 stage_4_en,
  output logic                 out_valid,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 busy,
  output logic                 err_sop,
  output logic [1:0]           dbg_state
);

  localparam int IW = $clog2(N);
  localparam logic [9:0]    EN64_T = EN64_DLY[9:0];
  localparam logic [9:0]    EN16_T = EN16_DLY[9:0];
  localparam logic [9:0]    EN4_T  = EN4_DLY[9:0];
  localparam logic [9:0]    OE_T   = OE_DLY[9:0];
  localparam logic [IW-1:0] LAST   = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [9:0]    tick;
  logic [IW-1:0] in_cnt, in_cnt_nxt;
  logic [2:0]    frames_pend, frames_pend_nxt;
  logic          flush_pend;

  logic adv_raw, advance, accept, wrap, go_idle;

  // Advance condition per state; gated by rst_n so nothing moves while reset
  // is being applied.
  always_comb begin
    adv_raw = 1'b0;
    case (state)
      S_IDLE:  adv_raw = in_valid & in_sop;
      S_RUN:   adv_raw = in_valid;
      S_FLUSH: adv_raw = 1'b1;
      default: adv_raw = 1'b0;
    endcase
  end

  assign advance  = rst_n & adv_raw;
  assign in_ready = ~rst_n | (state != S_FLUSH);
  assign accept   = advance & in_valid & (state != S_FLUSH);
  assign wrap     = accept & (in_cnt == LAST);

  assign in_cnt_nxt = accept ? in_cnt + IW'(1) : in_cnt;

  assign stage_256_en = advance;
  assign stage_64_en  = advance & (tick >= EN64_T);
  assign stage_16_en  = advance & (tick >= EN16_T);
  assign stage_4_en   = advance & (tick >= EN4_T);
  assign out_valid    = advance & (tick >= OE_T);
  assign out_sop      = out_valid & (out_idx == '0);
  assign out_eop      = out_valid & (out_idx == LAST);

  assign zero_fill = rst_n & (state == S_FLUSH);
  assign busy      = rst_n & (state != S_IDLE);
  assign dbg_state = state;

  assign err_sop = rst_n & in_valid &
                   (((state == S_IDLE) & ~in_sop) |
                    ((state == S_RUN) & in_sop & (in_cnt != '0)));

  // Frames fully accepted but not yet fully output. A completing input frame
  // and a completing output frame in the same cycle cancel out.
  always_comb begin
    frames_pend_nxt = frames_pend;
    case ({wrap, out_eop})
      2'b10:   frames_pend_nxt = frames_pend + 3'd1;
      2'b01:   frames_pend_nxt = frames_pend - 3'd1;
      default: frames_pend_nxt = frames_pend;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (advance) state_nxt = S_RUN;
      // Flush only at a frame boundary; a flush_req arriving with the
      // frame-completing sample counts immediately.
      S_RUN: if ((flush_pend | flush_req) && (in_cnt_nxt == '0)) state_nxt = S_FLUSH;
      S_FLUSH: begin
        if (frames_pend == '0)                          state_nxt = S_IDLE;
        else if (out_eop && (frames_pend_nxt == '0))    state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign go_idle = (state == S_FLUSH) && (state_nxt == S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      tick        <= '0;
      in_cnt      <= '0;
      out_idx     <= '0;
      frames_pend <= '0;
      flush_pend  <= 1'b0;
    end else begin
      state  <= state_nxt;
      in_cnt <= in_cnt_nxt;
      if (go_idle) begin
        tick        <= '0;
        out_idx     <= '0;
        frames_pend <= '0;
        flush_pend  <= 1'b0;
      end else begin
        if (advance && (tick != OE_T)) tick <= tick + 10'd1;
        if (out_valid) out_idx <= out_idx + IW'(1);
        frames_pend <= frames_pend_nxt;
        if ((state == S_RUN) && flush_req) flush_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
`timescale 1ns/1ps
module tb_fft_frame_sequencer;

  localparam int N  = 256;
  localparam int CW = 11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sop = 1'b0;
  logic       flush_req = 1'b0;
  logic       in_ready, zero_fill;
  logic       stage_256_en, stage_64_en, stage_16_en, stage_4_en;
  logic       out_valid, out_sop, out_eop, busy, err_sop;
  logic [7:0] out_idx;
  logic [1:0] dbg_state;

  fft_frame_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
    .in_ready(in_ready), .flush_req(flush_req), .zero_fill(zero_fill),
    .stage_256_en(stage_256_en), .stage_64_en(stage_64_en),
    .stage_16_en(stage_16_en), .stage_4_en(stage_4_en),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_idx(out_idx), .busy(busy), .err_sop(err_sop), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  logic [CW-1:0] exp_q[$];
  logic [7:0]    idx_q[$];
  int checks = 0;
  int errors = 0;
  int ov_seen = 0;

  // reference model: counts since the sequencer left IDLE
  int m_mode = 0;   // 0 idle, 1 streaming, 2 flushing
  int m_adv  = 0;   // advances
  int m_acc  = 0;   // accepted samples
  int m_out  = 0;   // output samples
  bit m_fp   = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // driver: one cycle of stimulus, expected response pushed to the queues
  task automatic step(input logic r, input logic v, input logic s, input logic f);
    bit ready, adv, err, ov, acc, eop;
    int idx, pend_before;
    @(posedge clk); #1;
    rst_n = r; in_valid = v; in_sop = s; flush_req = f;
    if (!r) begin
      exp_q.push_back({1'b1, 10'b0});
      m_mode = 0; m_adv = 0; m_acc = 0; m_out = 0; m_fp = 0;
    end else begin
      ready = (m_mode != 2);
      adv   = (m_mode == 0) ? (v && s) : (m_mode == 1) ? v : 1'b1;
      err   = v && ((m_mode == 0 && !s) || (m_mode == 1 && s && (m_acc % N) != 0));
      ov    = adv && (m_adv >= 258);
      idx   = m_out % N;
      eop   = ov && (idx == N - 1);
      exp_q.push_back({ready, m_mode == 2, adv, adv && (m_adv >= 193),
                       adv && (m_adv >= 242), adv && (m_adv >= 255), ov,
                       ov && (idx == 0), eop, m_mode != 0, err});
      if (ov) idx_q.push_back(8'(idx));
      acc = adv && ready;
      pend_before = m_acc / N - m_out / N;
      if (adv) m_adv++;
      if (acc) m_acc++;
      if (ov)  m_out++;
      case (m_mode)
        0: if (acc) m_mode = 1;
        1: begin
          if (f) m_fp = 1;
          if (m_fp && (m_acc % N) == 0) m_mode = 2;
        end
        default: begin
          if (pend_before == 0 || (eop && (m_acc / N - m_out / N) == 0)) begin
            m_mode = 0; m_adv = 0; m_acc = 0; m_out = 0; m_fp = 0;
          end
        end
      endcase
    end
  endtask

  // monitor
  always @(negedge clk) begin
    logic [CW-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {in_ready, zero_fill, stage_256_en, stage_64_en, stage_16_en, stage_4_en,
           out_valid, out_sop, out_eop, busy, err_sop};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL ctl act=%b exp=%b t=%0t", a, e, $time);
      end
    end
    if (out_valid === 1'b1) begin
      ov_seen++;
      checks++;
      if (idx_q.size() == 0) begin
        errors++;
        $display("FAIL out_extra act=idx%0d exp=none t=%0t", out_idx, $time);
      end else begin
        e[7:0] = idx_q.pop_front();
        if (out_idx !== e[7:0]) begin
          errors++;
          $display("FAIL out_idx act=%0d exp=%0d t=%0t", out_idx, e[7:0], $time);
        end
      end
    end
  end

  // sends n samples; sop on frame starts and at bad_sop_at, flush_req with
  // sample flush_at; gap_pct random idle cycles, or strict 1,0 alternation
  task automatic send(input int n, input int gap_pct, input int bad_sop_at,
                      input int flush_at, input bit alt);
    for (int k = 0; k < n; k++) begin
      if (alt) begin
        if (k > 0) step(1, 0, 0, 0);
      end else begin
        while ($urandom_range(99) < gap_pct) step(1, 0, 0, 0);
      end
      step(1, 1, ((k % N) == 0) || (k == bad_sop_at), k == flush_at);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (m_mode != 0 && n < 3000) begin
      step(1, 0, 0, 0);
      n++;
    end
    chk({name, "_timeout"}, int'(m_mode != 0), 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    @(negedge clk); #1;
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_idxq"}, idx_q.size(), 0);
  endtask

  initial begin
    int base;
    // reset state
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    @(negedge clk); #1;
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // two contiguous frames, then flush
    base = ov_seen;
    send(2 * N, 0, -1, -1, 0);
    step(1, 0, 0, 1);
    wait_idle("two_frames");
    chk("two_frames_count", ov_seen - base, 2 * N);

    // 50% gated input, flush with the last sample
    base = ov_seen;
    send(N, 0, -1, N - 1, 1);
    wait_idle("gated");
    chk("gated_count", ov_seen - base, N);

    // in_valid without sop while idle
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    @(negedge clk); #1;
    chk("idle_nosop_busy", int'(busy), 0);

    // stray sop at in_cnt=100, flush_req at in_cnt=37
    base = ov_seen;
    send(N, 20, 100, 37, 0);
    wait_idle("sop_flush");
    chk("sop_flush_count", ov_seen - base, N);

    // reset mid-frame at tick 200, then a full frame
    send(200, 0, -1, -1, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    @(negedge clk); #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_idx", int'(out_idx), 0);
    base = ov_seen;
    send(N, 0, -1, N - 1, 0);
    wait_idle("after_rst");
    chk("after_rst_count", ov_seen - base, N);

    // random: three frames, random gaps, stray sop, late flush
    base = ov_seen;
    send(3 * N, 30, N + $urandom_range(1, N - 1), 2 * N + $urandom_range(0, N - 1), 0);
    wait_idle("random");
    chk("random_count", ov_seen - base, 3 * N);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
